// File: rtl/mem_stage_if.sv
// Interface bundling the MEM stage upstream, downstream, data-SRAM and bypass signals.
interface mem_stage_if;
  // Upstream (EX -> MEM)
  logic        ex_to_mem_valid;
  logic        mem_allow_in;
  logic [31:0] ex_pc;
  logic [31:0] ex_result;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        ex_mem_req;
  logic [2:0]  ex_ld_op;
  logic [15:0] ex_ebus;
  // Data SRAM load response
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  // Downstream (MEM -> WB)
  logic        mem_to_wb_valid;
  logic        wb_allow_in;
  logic [31:0] wb_pc;
  logic [31:0] wb_final_result;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [15:0] wb_ebus;
  // Flush from WB
  logic        flush;
  // Bypass to ID
  logic        byp_we;
  logic [4:0]  byp_waddr;
  logic [31:0] byp_wdata;
  logic        byp_block;

  // Environment side: drives pipeline inputs, observes MEM outputs.
  modport master (
    output ex_to_mem_valid, ex_pc, ex_result, ex_rf_we, ex_rf_waddr, ex_mem_req, ex_ld_op,
           ex_ebus, data_sram_data_ok, data_sram_rdata, wb_allow_in, flush,
    input  mem_allow_in, mem_to_wb_valid, wb_pc, wb_final_result, wb_rf_we, wb_rf_waddr,
           wb_ebus, byp_we, byp_waddr, byp_wdata, byp_block
  );

  // MEM stage side.
  modport slave (
    input  ex_to_mem_valid, ex_pc, ex_result, ex_rf_we, ex_rf_waddr, ex_mem_req, ex_ld_op,
           ex_ebus, data_sram_data_ok, data_sram_rdata, wb_allow_in, flush,
    output mem_allow_in, mem_to_wb_valid, wb_pc, wb_final_result, wb_rf_we, wb_rf_waddr,
           wb_ebus, byp_we, byp_waddr, byp_wdata, byp_block
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, collects its load response (possibly late or
// while WB is stalled), aligns/extends load data and discards responses of flushed loads.
module mem_stage (
  input logic         clk,
  input logic         resetn,
  mem_stage_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic        mem_valid_q, mem_valid_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_q, result_q;
  logic        rf_we_q;
  logic [4:0]  waddr_q;
  logic [2:0]  ld_op_q;
  logic [15:0] ebus_q;

  logic        data_ok;
  logic        wait_hit;
  logic        ready_go;
  logic        up_fire;
  logic        out_fire;
  logic        ex_load_wait;
  logic        drop_inc;
  logic        drop_dec;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] final_result;
  logic        rf_we_eff;

  // A response only belongs to us when no flushed load is still owed one.
  assign data_ok      = bus.data_sram_data_ok & (drop_cnt_q == 2'd0);
  assign wait_hit     = (state_q == StWait) & data_ok;
  assign ready_go     = ~mem_valid_q | (state_q != StWait) | data_ok;
  assign out_fire     = bus.mem_to_wb_valid & bus.wb_allow_in;
  assign up_fire      = bus.ex_to_mem_valid & bus.mem_allow_in & ~bus.flush;
  assign ex_load_wait = bus.ex_mem_req & (bus.ex_ebus == 16'd0);
  assign drop_inc     = bus.flush & mem_valid_q & (state_q == StWait) & ~data_ok;
  assign drop_dec     = bus.data_sram_data_ok & (drop_cnt_q != 2'd0);

  assign bus.mem_to_wb_valid = mem_valid_q & ready_go & ~bus.flush;
  assign bus.mem_allow_in    = (~mem_valid_q | (ready_go & bus.wb_allow_in)) &
                               ~((drop_cnt_q != 2'd0) & ~bus.data_sram_data_ok);

  // Load data alignment and extension; live rdata is forwarded on the response cycle.
  always_comb begin
    ld_word = wait_hit ? bus.data_sram_rdata : buf_q;
    unique case (result_q[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = result_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_op_q)
      3'd1:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_ext = {24'd0, ld_byte};
      3'd3:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {16'd0, ld_half};
      default: ld_ext = ld_word;
    endcase
    final_result = (ld_op_q != 3'd0) ? ld_ext : result_q;
  end

  assign rf_we_eff           = rf_we_q & mem_valid_q & (ebus_q == 16'd0);
  assign bus.wb_pc           = pc_q;
  assign bus.wb_final_result = final_result;
  assign bus.wb_rf_we        = rf_we_eff;
  assign bus.wb_rf_waddr     = waddr_q;
  assign bus.wb_ebus         = ebus_q;
  assign bus.byp_we          = rf_we_eff & (waddr_q != 5'd0);
  assign bus.byp_waddr       = waddr_q;
  assign bus.byp_wdata       = final_result;
  assign bus.byp_block       = mem_valid_q & (ld_op_q != 3'd0) & (state_q == StWait) & ~data_ok;

  // Next-state: later assignments take priority (flush over transfer over departure).
  always_comb begin
    mem_valid_d = mem_valid_q;
    state_d     = state_q;
    buf_d       = data_ok ? bus.data_sram_rdata : buf_q;
    if (wait_hit) state_d = StHold;
    if (out_fire) begin
      mem_valid_d = 1'b0;
      state_d     = StIdle;
    end
    if (up_fire) begin
      mem_valid_d = 1'b1;
      if (!ex_load_wait)              state_d = StIdle;
      else if (data_ok && !wait_hit)  state_d = StHold;
      else                            state_d = StWait;
    end
    if (bus.flush) begin
      mem_valid_d = 1'b0;
      state_d     = StIdle;
    end
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_dec && drop_cnt_q != 2'd3) drop_cnt_d = drop_cnt_q + 2'd1;
    else if (!drop_inc && drop_dec)                  drop_cnt_d = drop_cnt_q - 2'd1;
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      state_q     <= StIdle;
      drop_cnt_q  <= 2'd0;
      buf_q       <= 32'd0;
      pc_q        <= 32'd0;
      result_q    <= 32'd0;
      rf_we_q     <= 1'b0;
      waddr_q     <= 5'd0;
      ld_op_q     <= 3'd0;
      ebus_q      <= 16'd0;
    end else begin
      mem_valid_q <= mem_valid_d;
      state_q     <= state_d;
      drop_cnt_q  <= drop_cnt_d;
      buf_q       <= buf_d;
      if (up_fire) begin
        pc_q     <= bus.ex_pc;
        result_q <= bus.ex_result;
        rf_we_q  <= bus.ex_rf_we;
        waddr_q  <= bus.ex_rf_waddr;
        ld_op_q  <= bus.ex_ld_op;
        ebus_q   <= bus.ex_ebus;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized run scored against a
// transaction-level model (in-order expected queue, load values computed arithmetically).
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic        we;
    logic [15:0] ebus;
  } exp_t;

  // Expected load value from the load-op rules using plain shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return word;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.ex_to_mem_valid   = 1'b0;
    bus.ex_pc             = 32'd0;
    bus.ex_result         = 32'd0;
    bus.ex_rf_we          = 1'b0;
    bus.ex_rf_waddr       = 5'd0;
    bus.ex_mem_req        = 1'b0;
    bus.ex_ld_op          = 3'd0;
    bus.ex_ebus           = 16'd0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'd0;
    bus.wb_allow_in       = 1'b1;
    bus.flush             = 1'b0;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] res, input logic we,
                          input logic [4:0] wa, input logic req, input logic [2:0] op,
                          input logic [15:0] eb);
    bus.ex_to_mem_valid = 1'b1;
    bus.ex_pc           = pc;
    bus.ex_result       = res;
    bus.ex_rf_we        = we;
    bus.ex_rf_waddr     = wa;
    bus.ex_mem_req      = req;
    bus.ex_ld_op        = op;
    bus.ex_ebus         = eb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++; if (bus.mem_allow_in !== 1'b1) begin n_fail++;
      $display("FAIL reset_allow_in: got %b want 1", bus.mem_allow_in); end
    n_tests++; if (bus.mem_to_wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_to_wb_valid: got %b want 0", bus.mem_to_wb_valid); end
    n_tests++; if ({bus.byp_we, bus.byp_block, bus.wb_rf_we} !== 3'b000) begin n_fail++;
      $display("FAIL reset_byp: got %b want 000", {bus.byp_we, bus.byp_block, bus.wb_rf_we}); end
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
    @(negedge clk);
    n_tests++; if (bus.mem_allow_in !== 1'b1 || bus.mem_to_wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_idle: got allow=%b valid=%b want 1/0",
               bus.mem_allow_in, bus.mem_to_wb_valid); end
    tick();
  endtask

  task automatic test_ld_b();
    int blocked = 0;
    drive_ex(32'h1C00_0010, 32'h0000_1003, 1'b1, 5'd5, 1'b1, 3'd1, 16'd0);
    @(negedge clk);
    n_tests++; if (bus.mem_allow_in !== 1'b1) begin n_fail++;
      $display("FAIL ldb_accept: got %b want 1", bus.mem_allow_in); end
    tick();
    bus.ex_to_mem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.byp_block === 1'b1) blocked++;
      n_tests++; if (bus.mem_to_wb_valid !== 1'b0) begin n_fail++;
        $display("FAIL ldb_wait_valid: got %b want 0", bus.mem_to_wb_valid); end
      tick();
    end
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h80FF_1234;
    @(negedge clk);
    if (bus.byp_block === 1'b1) blocked++;
    n_tests++; if (bus.mem_to_wb_valid !== 1'b1 || bus.wb_final_result !== 32'hFFFF_FF80)
      begin n_fail++; $display("FAIL ldb_result: got valid=%b data=%h want 1/ffffff80",
                               bus.mem_to_wb_valid, bus.wb_final_result); end
    n_tests++; if (bus.byp_we !== 1'b1 || bus.byp_wdata !== 32'hFFFF_FF80) begin n_fail++;
      $display("FAIL ldb_bypass: got we=%b data=%h want 1/ffffff80", bus.byp_we, bus.byp_wdata);
    end
    tick();
    bus.data_sram_data_ok = 1'b0;
    n_tests++; if (blocked != 2) begin n_fail++;
      $display("FAIL ldb_block_cycles: got %0d want 2", blocked); end
    @(negedge clk);
    n_tests++; if (bus.mem_to_wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL ldb_retired: got %b want 0", bus.mem_to_wb_valid); end
    tick();
  endtask

  task automatic test_ld_hu_hold();
    bus.wb_allow_in = 1'b0;
    drive_ex(32'h1C00_0020, 32'h0000_2002, 1'b1, 5'd6, 1'b1, 3'd4, 16'd0);
    tick();
    bus.ex_to_mem_valid   = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hBEEF_0000;
    @(negedge clk);
    n_tests++; if (bus.mem_to_wb_valid !== 1'b1) begin n_fail++;
      $display("FAIL hold_resp_valid: got %b want 1", bus.mem_to_wb_valid); end
    tick();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h5555_5555;
    @(negedge clk);
    n_tests++; if (bus.wb_final_result !== 32'h0000_BEEF || bus.mem_allow_in !== 1'b0)
      begin n_fail++; $display("FAIL hold_buffer: got data=%h allow=%b want 0000beef/0",
                               bus.wb_final_result, bus.mem_allow_in); end
    n_tests++; if (bus.byp_block !== 1'b0 || bus.mem_to_wb_valid !== 1'b1) begin n_fail++;
      $display("FAIL hold_flags: got block=%b valid=%b want 0/1",
               bus.byp_block, bus.mem_to_wb_valid); end
    tick();
    bus.wb_allow_in = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.wb_final_result !== 32'h0000_BEEF || bus.wb_rf_waddr !== 5'd6) begin
      n_fail++; $display("FAIL hold_release: got data=%h waddr=%0d want 0000beef/6",
                         bus.wb_final_result, bus.wb_rf_waddr); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.mem_to_wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL hold_retired: got %b want 0", bus.mem_to_wb_valid); end
    tick();
  endtask

  task automatic test_flush_drop();
    drive_ex(32'h1C00_0030, 32'h0000_0100, 1'b1, 5'd3, 1'b1, 3'd5, 16'd0);
    tick();
    bus.ex_to_mem_valid = 1'b0;
    bus.flush           = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.mem_to_wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_valid: got %b want 0", bus.mem_to_wb_valid); end
    tick();
    bus.flush = 1'b0;
    drive_ex(32'h1C00_0034, 32'h0000_0104, 1'b1, 5'd4, 1'b1, 3'd5, 16'd0);
    @(negedge clk);
    n_tests++; if (bus.mem_allow_in !== 1'b0) begin n_fail++;
      $display("FAIL drop_block_in: got %b want 0", bus.mem_allow_in); end
    tick();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0000_0011;
    @(negedge clk);
    n_tests++; if (bus.mem_allow_in !== 1'b1) begin n_fail++;
      $display("FAIL drop_allow_on_ok: got %b want 1", bus.mem_allow_in); end
    tick();
    bus.ex_to_mem_valid   = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.byp_block !== 1'b1 || bus.mem_to_wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL drop_second_wait: got block=%b valid=%b want 1/0",
               bus.byp_block, bus.mem_to_wb_valid); end
    tick();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0000_0022;
    @(negedge clk);
    n_tests++; if (bus.mem_to_wb_valid !== 1'b1 || bus.wb_final_result !== 32'h22 ||
                   bus.wb_rf_waddr !== 5'd4) begin n_fail++;
      $display("FAIL drop_second_data: got valid=%b data=%h waddr=%0d want 1/22/4",
               bus.mem_to_wb_valid, bus.wb_final_result, bus.wb_rf_waddr); end
    tick();
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_exception();
    drive_ex(32'h1C00_0041, 32'h0000_DEAD, 1'b1, 5'd7, 1'b0, 3'd0, 16'h0040);
    tick();
    bus.ex_to_mem_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.mem_to_wb_valid !== 1'b1 || bus.wb_ebus !== 16'h0040 ||
                   bus.wb_pc !== 32'h1C00_0041) begin n_fail++;
      $display("FAIL exc_pass: got valid=%b ebus=%h pc=%h want 1/0040/1c000041",
               bus.mem_to_wb_valid, bus.wb_ebus, bus.wb_pc); end
    n_tests++; if (bus.wb_rf_we !== 1'b0 || bus.byp_we !== 1'b0) begin n_fail++;
      $display("FAIL exc_no_write: got rf_we=%b byp_we=%b want 0/0", bus.wb_rf_we, bus.byp_we);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_res;
    logic [4:0]  prev_wa;
    for (int i = 0; i < 8; i++) begin
      drive_ex(32'h1C00_1000 + 4 * i, 32'h0101_0000 + 32'(i * 7), 1'b1,
               (i == 3) ? 5'd0 : 5'(i + 10), 1'b0, 3'd0, 16'd0);
      @(negedge clk);
      n_tests++; if (bus.mem_allow_in !== 1'b1) begin n_fail++;
        $display("FAIL b2b_allow[%0d]: got %b want 1", i, bus.mem_allow_in); end
      if (i > 0) begin
        n_tests++; if (bus.mem_to_wb_valid !== 1'b1 || bus.wb_final_result !== prev_res ||
                       bus.byp_we !== (prev_wa != 5'd0)) begin n_fail++;
          $display("FAIL b2b_out[%0d]: got valid=%b data=%h byp_we=%b want 1/%h/%b", i,
                   bus.mem_to_wb_valid, bus.wb_final_result, bus.byp_we, prev_res,
                   prev_wa != 5'd0); end
      end
      prev_res = bus.ex_result;
      prev_wa  = bus.ex_rf_waddr;
      tick();
    end
    bus.ex_to_mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    drive_ex(32'h1C00_0050, 32'h0000_0200, 1'b1, 5'd9, 1'b1, 3'd5, 16'd0);
    tick();
    bus.ex_to_mem_valid = 1'b0;
    resetn = 1'b0;
    tick();
    @(negedge clk);
    n_tests++; if (bus.mem_allow_in !== 1'b1 || bus.mem_to_wb_valid !== 1'b0 ||
                   bus.byp_block !== 1'b0 || bus.byp_we !== 1'b0) begin n_fail++;
      $display("FAIL rst_wait_outputs: got allow=%b valid=%b block=%b we=%b want 1/0/0/0",
               bus.mem_allow_in, bus.mem_to_wb_valid, bus.byp_block, bus.byp_we); end
    tick();
    resetn = 1'b1;
    drive_ex(32'h1C00_0060, 32'h0000_0202, 1'b1, 5'd9, 1'b1, 3'd4, 16'd0);
    @(negedge clk);
    n_tests++; if (bus.mem_allow_in !== 1'b1) begin n_fail++;
      $display("FAIL rst_wait_accept: got %b want 1", bus.mem_allow_in); end
    tick();
    bus.ex_to_mem_valid   = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hCAFE_1234;
    @(negedge clk);
    n_tests++; if (bus.mem_to_wb_valid !== 1'b1 || bus.wb_final_result !== 32'h0000_CAFE)
      begin n_fail++; $display("FAIL rst_wait_load: got valid=%b data=%h want 1/0000cafe",
                               bus.mem_to_wb_valid, bus.wb_final_result); end
    tick();
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_random();
    exp_t        expq[$];
    logic [31:0] pend[$];
    exp_t        cur_exp;
    exp_t        got;
    logic [31:0] cur_rdata;
    logic        have = 1'b0;
    int          sent = 0, done = 0, cyc = 0;
    localparam int N = 200;
    while (done < N && cyc < 8000) begin
      if (!have && sent < N) begin
        have = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          drive_ex($urandom, $urandom, 1'b1, 5'($urandom), 1'b1, 3'($urandom_range(1, 5)),
                   16'd0);
          cur_rdata   = $urandom;
          cur_exp.res = ref_load(bus.ex_ld_op, bus.ex_result, cur_rdata);
        end else begin
          drive_ex($urandom, $urandom, 1'($urandom), 5'($urandom), 1'b0, 3'd0,
                   ($urandom_range(0, 7) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0);
          cur_exp.res = bus.ex_result;
        end
        cur_exp.pc   = bus.ex_pc;
        cur_exp.ebus = bus.ex_ebus;
        cur_exp.we   = bus.ex_rf_we & (bus.ex_ebus == 16'd0);
      end
      bus.ex_to_mem_valid   = have & ($urandom_range(0, 3) != 0);
      bus.wb_allow_in       = ($urandom_range(0, 3) != 0);
      bus.data_sram_data_ok = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.data_sram_rdata   = bus.data_sram_data_ok ? pend[0] : $urandom;
      @(negedge clk);
      if (bus.mem_to_wb_valid && bus.wb_allow_in) begin
        got = '{pc: bus.wb_pc, res: bus.wb_final_result, we: bus.wb_rf_we, ebus: bus.wb_ebus};
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: got pc=%h want no output", got.pc);
        end else begin
          if (got !== expq[0]) begin n_fail++;
            $display("FAIL rand_out[%0d]: got pc=%h res=%h we=%b eb=%h want %h/%h/%b/%h",
                     done, got.pc, got.res, got.we, got.ebus,
                     expq[0].pc, expq[0].res, expq[0].we, expq[0].ebus); end
          void'(expq.pop_front());
        end
        done++;
      end
      if (bus.ex_to_mem_valid && bus.mem_allow_in) begin
        expq.push_back(cur_exp);
        if (bus.ex_mem_req) pend.push_back(cur_rdata);
        have = 1'b0;
        sent++;
      end
      if (bus.data_sram_data_ok) void'(pend.pop_front());
      tick();
      cyc++;
    end
    n_tests++; if (done != N) begin n_fail++;
      $display("FAIL rand_timeout: got %0d retired want %0d", done, N); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_ld_b();
    test_ld_hu_hold();
    test_flush_drop();
    test_exception();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  in  1  reset, synchronous and active-low.
REQ-003 SHALL have ports ex_to_mem_valid in 1, mem_allow_in out 1  upstream handshake; a transfer occurs when both are 1 at a rising edge.
REQ-004 SHALL have upstream payload inputs:
- ex_pc in 32
- ex_result in 32 (ALU result or load address)
- ex_rf_we in 1, ex_rf_waddr in 5
- ex_mem_req in 1 (load request already accepted by data SRAM in EX)
- ex_ld_op in 3 (0=none, 1=ld.b, 2=ld.bu, 3=ld.h, 4=ld.hu, 5=ld.w)
- ex_ebus in 16 (exception bits)
REQ-005 SHALL have ports data_sram_data_ok in 1, data_sram_rdata in 32  load response; exactly one response per accepted request, in order.
REQ-006 SHALL have ports mem_to_wb_valid out 1, wb_allow_in in 1  downstream handshake.
REQ-007 SHALL have downstream payload outputs:
- wb_pc out 32
- wb_final_result out 32
- wb_rf_we out 1, wb_rf_waddr out 5
- wb_ebus out 16
REQ-008 SHALL have port flush in 1  exception/ertn/refetch flush from WB.
REQ-009 SHALL have bypass outputs:
- byp_we out 1, byp_waddr out 5, byp_wdata out 32
- byp_block out 1 (value not yet available)

Function
REQ-010 SHALL hold one instruction in registers (mem_valid plus captured payload), loaded on an upstream transfer.
REQ-011 SHALL have the following state machine:
- IDLE: no outstanding response.
- WAIT: load issued, response not yet received.
- HOLD: response captured in a 32-bit buffer, awaiting downstream transfer.
REQ-012 SHALL enter WAIT on a transfer with ex_mem_req=1 and ex_ebus=0, unless data_sram_data_ok is high that same edge.
REQ-013 SHALL, in WAIT with data_ok=1, capture rdata into the buffer: go to HOLD if wb_allow_in=0, or to IDLE if the instruction leaves the same cycle.
REQ-014 SHALL assert mem_ready_go (internal) = ~mem_valid | state!=WAIT | data_ok; drive mem_to_wb_valid = mem_valid & mem_ready_go & ~flush.
REQ-015 SHALL assert mem_allow_in = ~mem_valid | (mem_ready_go & wb_allow_in), and 0 while drop_cnt!=0 and data_ok=0.
REQ-016 SHALL select load data from the live rdata when in WAIT with data_ok=1, otherwise from the buffer.
REQ-017 SHALL extract the byte or half using result[1:0] (half uses result[1]) and sign- or zero-extend it per ld_op, zero-latency combinational.
REQ-018 SHALL drive wb_final_result = extended load data when ld_op!=0, else the captured result.
REQ-019 SHALL drive wb_rf_we = captured rf_we & mem_valid & (ebus==0).
REQ-020 SHALL pass wb_ebus and wb_pc through unchanged from the captured payload.
REQ-021 SHALL, on flush, clear mem_valid and state next edge; if state is WAIT and data_ok=0, increment a 2-bit drop_cnt.
REQ-022 SHALL discard any data_ok while drop_cnt!=0 (decrement, no capture); drop_cnt saturates at 3.
REQ-023 SHALL block an upstream transfer coincident with flush (upstream is flushed too).
REQ-024 SHALL drive byp_we = mem_valid & rf_we & (ebus==0); byp_waddr/byp_wdata = wb_rf_waddr/wb_final_result.
REQ-025 SHALL drive byp_block = mem_valid & (ld_op!=0) & state==WAIT & ~data_ok.
REQ-026 SHALL ensure that writes to waddr 0 never assert byp_we.

Reset
REQ-027 SHALL, while resetn=0 at an edge, clear mem_valid, state=IDLE, drop_cnt=0, buffer=0.
REQ-028 SHALL hold all handshake and bypass outputs at 0 except mem_allow_in=1 during and after reset until the first transfer.
REQ-029 SHALL ensure a reset while in WAIT does not increment drop_cnt (memory side reset together).

Verification
REQ-030 SHALL cover: ld.b at addr 0x...3, data_ok 2 cycles later with rdata 0x80FF_1234 -> wb_final_result 0xFFFF_FF80, byp_block high exactly 2 cycles.
REQ-031 SHALL cover: ld.hu addr ...2, data_ok same cycle as wb_allow_in=0, rdata 0xBEEF_0000 -> HOLD, final 0x0000_BEEF when wb_allow_in rises.
REQ-032 SHALL cover: flush while WAIT, next load accepted, two data_ok (0x11, 0x22) -> first dropped, second load writes 0x22.
REQ-033 SHALL cover: non-load with ex_ebus[ADEF]=1, ex_rf_we=1 -> mem_to_wb_valid next cycle, wb_rf_we=0, byp_we=0.
REQ-034 SHALL cover: back-to-back ALU ops with wb_allow_in=1 -> one per cycle, no bubbles, mem_allow_in constant 1.
REQ-035 SHALL cover: resetn low during WAIT -> outputs per REQ-028, drop_cnt=0, next load completes normally.
